// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration sequencer.
// Field offsets describe the layout of one per-pad configuration word.
package pad_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        FIN
    } state_e;

    localparam int          CFG_BITS_DEF  = 13;
    localparam logic [12:0] CFG_RESET_DEF = 13'h0403;

    localparam int FLD_MGMT_EN     = 0;
    localparam int FLD_OEB         = 1;
    localparam int FLD_HOLDOVER    = 2;
    localparam int FLD_INP_DIS     = 3;
    localparam int FLD_IB_MODE_SEL = 4;
    localparam int FLD_ANALOG_EN   = 5;
    localparam int FLD_ANALOG_SEL  = 6;
    localparam int FLD_ANALOG_POL  = 7;
    localparam int FLD_SLOW_SEL    = 8;
    localparam int FLD_VTRIP_SEL   = 9;
    localparam int FLD_DM_LSB      = 10;
    localparam int FLD_DM_MSB      = 12;

endpackage

// File: rtl/pad_cfg_chain_shift.sv
// One serial chain: picks the addressed pad word and bit from the shared
// counters and registers the bit driven onto this chain's data line.
module pad_cfg_chain_shift
    import pad_cfg_pkg::*;
#(
    parameter int PADS     = 19,
    parameter int CFG_BITS = CFG_BITS_DEF,
    parameter int PW       = (PADS > 1) ? $clog2(PADS) : 1,
    parameter int BW       = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          upd,
    input  logic [PADS-1:0][CFG_BITS-1:0] words,
    input  logic [PW-1:0]                 pad_sel,
    input  logic [BW-1:0]                 bit_sel,
    output logic                          sdo
);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sdo <= 1'b0;
        end else if (upd) begin
            sdo <= words[pad_sel][bit_sel];
        end
    end

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Pad-ring configuration sequencer: register file of per-pad words, shifted
// MSB-first over parallel chains (farthest pad first), then a 2-cycle load.
module pad_cfg_sequencer
    import pad_cfg_pkg::*;
#(
    parameter int                  NUM_PADS   = 38,
    parameter int                  NUM_CHAINS = 2,
    parameter int                  CFG_BITS   = CFG_BITS_DEF,
    parameter logic [CFG_BITS-1:0] CFG_RESET  = CFG_RESET_DEF
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_PADS)-1:0] wr_addr,
    input  logic [CFG_BITS-1:0]         wr_data,
    output logic                        wr_err,
    input  logic [$clog2(NUM_PADS)-1:0] rd_addr,
    output logic [CFG_BITS-1:0]         rd_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        serial_clock,
    output logic                        serial_load,
    output logic [NUM_CHAINS-1:0]       serial_data_out
);

    localparam int AW = $clog2(NUM_PADS);
    localparam int P  = NUM_PADS / NUM_CHAINS;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    localparam logic [PW-1:0] PAD_LAST = PW'(P - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(CFG_BITS - 1);
    localparam logic [AW:0]   PAD_LIM  = (AW + 1)'(NUM_PADS);

    state_e        state_q, state_d;
    logic          phase_q, phase_d;
    logic          ld_cnt_q, ld_cnt_d;
    logic [PW-1:0] pad_q, pad_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_d, sload_d, done_d, shift_upd;
    logic          wr_in_range, rd_in_range, wr_ok;

    logic [NUM_PADS-1:0][CFG_BITS-1:0] rf_q, rf_d;

    assign wr_in_range = {1'b0, wr_addr} < PAD_LIM;
    assign rd_in_range = {1'b0, rd_addr} < PAD_LIM;
    assign wr_ok       = wr_en && wr_in_range && (state_q == IDLE);

    // Chains see the post-write file so a write and start in one cycle
    // shifts out the freshly written word.
    always_comb begin
        rf_d = rf_q;
        if (wr_ok) begin
            rf_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ld_cnt_d  = ld_cnt_q;
        pad_d     = pad_q;
        bit_d     = bit_q;
        sclk_d    = 1'b0;
        sload_d   = 1'b0;
        done_d    = 1'b0;
        shift_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    phase_d   = 1'b0;
                    pad_d     = PAD_LAST;
                    bit_d     = BIT_MSB;
                    shift_upd = 1'b1;
                end
            end
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else if (pad_q == '0 && bit_q == '0) begin
                    state_d  = LOAD;
                    phase_d  = 1'b0;
                    ld_cnt_d = 1'b0;
                    sload_d  = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    shift_upd = 1'b1;
                    if (bit_q == '0) begin
                        bit_d = BIT_MSB;
                        pad_d = pad_q - 1'b1;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
            LOAD: begin
                if (!ld_cnt_q) begin
                    ld_cnt_d = 1'b1;
                    sload_d  = 1'b1;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            ld_cnt_q     <= 1'b0;
            pad_q        <= '0;
            bit_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_load  <= 1'b0;
            wr_err       <= 1'b0;
            rd_data      <= '0;
            rf_q         <= {NUM_PADS{CFG_RESET}};
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ld_cnt_q     <= ld_cnt_d;
            pad_q        <= pad_d;
            bit_q        <= bit_d;
            busy         <= (state_d != IDLE);
            done         <= done_d;
            serial_clock <= sclk_d;
            serial_load  <= sload_d;
            wr_err       <= wr_en && !wr_ok;
            rd_data      <= rd_in_range ? rf_q[rd_addr] : '0;
            rf_q         <= rf_d;
        end
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        pad_cfg_chain_shift #(
            .PADS    (P),
            .CFG_BITS(CFG_BITS)
        ) u_shift (
            .clock  (clock),
            .resetb (resetb),
            .upd    (shift_upd),
            .words  (rf_d[c*P +: P]),
            .pad_sel(pad_d),
            .bit_sel(bit_d),
            .sdo    (serial_data_out[c])
        );
    end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Randomized scoreboard bench for pad_cfg_sequencer against a word-level
// reference model of the register file and the shift/load timeline.
module tb_pad_cfg_sequencer;

    localparam int NUM_PADS = 38;
    localparam int NC       = 2;
    localparam int CB       = 13;
    localparam int P        = NUM_PADS / NC;
    localparam int N        = P * CB;
    localparam int AW       = $clog2(NUM_PADS);
    localparam logic [CB-1:0] RST_WORD = 13'h0403;

    logic          clock = 1'b0;
    logic          resetb = 1'b0;
    logic          wr_en = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [CB-1:0] wr_data = '0;
    logic          wr_err, busy, done, serial_clock, serial_load;
    logic [CB-1:0] rd_data;
    logic [NC-1:0] serial_data_out;

    pad_cfg_sequencer dut (
        .clock          (clock),
        .resetb         (resetb),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .serial_clock   (serial_clock),
        .serial_load    (serial_load),
        .serial_data_out(serial_data_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int due; logic [CB-1:0] rd; logic err; } rsp_t;
    typedef struct { int due; logic [NC-1:0] v; } bit_t;

    rsp_t          rsp_q[$];
    bit_t          bit_q[$];
    int            seq_q[$];
    logic [CB-1:0] model_rf[NUM_PADS];
    int            busy_until;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_PADS; i++) model_rf[i] = RST_WORD;
        rsp_q.delete();
        bit_q.delete();
        seq_q.delete();
    endtask

    // Drive one cycle of inputs and record what the ring must do in response.
    // A sequence accepted at edge t keeps the block busy through edge t+2N+2.
    task automatic step(logic we, int wa, logic [CB-1:0] wd, int ra, logic st);
        int   t;
        logic idle, ok;
        rsp_t r;
        bit_t b;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_addr = AW'(ra);
        start   = st;
        t       = cyc + 1;
        idle    = (t > busy_until);
        r.due   = t;
        r.rd    = (ra < NUM_PADS) ? model_rf[ra] : '0;
        ok      = we && idle && (wa < NUM_PADS);
        r.err   = we && !ok;
        rsp_q.push_back(r);
        if (ok) model_rf[wa] = wd;
        if (st && idle) begin
            seq_q.push_back(t);
            busy_until = t + 2*N + 3;
            for (int k = 0; k < N; k++) begin
                b.due = t + 2*k;
                for (int c = 0; c < NC; c++)
                    b.v[c] = model_rf[c*P + (P-1) - k/CB][(CB-1) - k%CB];
                bit_q.push_back(b);
            end
        end
        @(posedge clock);
        #2;
    endtask

    task automatic run_rand(int n, int pw, int ps, int fixed_wa);
        for (int i = 0; i < n; i++) begin
            int wa;
            wa = (fixed_wa >= 0) ? fixed_wa : int'($urandom_range(63));
            step($urandom_range(99) < pw, wa, CB'($urandom), int'($urandom_range(63)),
                 $urandom_range(99) < ps);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, " busy"},            32'(busy),            0);
        chk({tag, " done"},            32'(done),            0);
        chk({tag, " wr_err"},          32'(wr_err),          0);
        chk({tag, " serial_clock"},    32'(serial_clock),    0);
        chk({tag, " serial_load"},     32'(serial_load),     0);
        chk({tag, " serial_data_out"}, 32'(serial_data_out), 0);
        chk({tag, " rd_data"},         32'(rd_data),         0);
    endtask

    always @(negedge clock) begin
        logic [3:0] exp_ctl;
        int         d;
        rsp_t       r;
        if (resetb) begin
            while (seq_q.size() > 0 && cyc > seq_q[0] + 2*N + 2) void'(seq_q.pop_front());
            exp_ctl = '0;
            if (seq_q.size() > 0 && cyc >= seq_q[0]) begin
                d = cyc - seq_q[0];
                exp_ctl = {1'b1, (d < 2*N) && (d % 2 == 1),
                           (d == 2*N) || (d == 2*N + 1), d == 2*N + 2};
            end
            chk("busy/sclk/load/done", 32'({busy, serial_clock, serial_load, done}), 32'(exp_ctl));
            if (bit_q.size() > 0 && cyc >= bit_q[0].due) begin
                chk("serial_data_out", 32'(serial_data_out), 32'(bit_q[0].v));
                if (cyc > bit_q[0].due) void'(bit_q.pop_front());
            end
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(r.rd));
                chk("wr_err",  32'(wr_err),  32'(r.err));
            end
        end
    end

    initial begin
        busy_until = -1;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        chk_reset("por");
        resetb     = 1'b1;
        busy_until = cyc;

        // Default words through both chains.
        for (int i = 0; i < 4; i++) step(0, 0, '0, int'($urandom_range(NUM_PADS-1)), 0);
        step(0, 0, '0, 0, 1);
        run_rand(2*N + 8, 0, 0, -1);

        // Extreme words at far and near ends of chain 0, plus out-of-range access.
        step(1, 18, 13'h1FFF, 18, 0);
        step(1, 0, 13'h0001, 0, 0);
        step(1, 40, 13'h1ABC, 40, 0);
        step(0, 0, '0, 40, 0);
        step(0, 0, '0, 18, 1);
        run_rand(2*N + 8, 0, 0, -1);

        // Writes to pad 5 and stray start pulses while shifting.
        step(0, 0, '0, 5, 1);
        run_rand(2*N + 8, 30, 5, 5);
        run_rand(2*N + 8, 0, 0, -1);

        // Random writes, then write+start in one cycle with start held high.
        run_rand(12, 80, 0, -1);
        step(1, int'($urandom_range(NUM_PADS-1)), CB'($urandom), 0, 1);
        run_rand(2*N + 20, 20, 100, -1);
        run_rand(2*N + 8, 20, 0, -1);

        // Asynchronous reset 100 cycles into a shift.
        step(0, 0, '0, 0, 1);
        run_rand(100, 0, 0, -1);
        resetb = 1'b0;
        model_reset();
        #1;
        chk_reset("mid-shift reset");
        @(posedge clock);
        @(posedge clock);
        #2;
        resetb     = 1'b1;
        busy_until = cyc;
        for (int i = 0; i < NUM_PADS; i++) step(0, 0, '0, i, 0);
        step(1, 40, 13'h0FFF, 40, 0);
        run_rand(10, 0, 0, -1);

        @(negedge clock);
        #1;
        chk("bit queue drained", 32'(bit_q.size()), 0);
        chk("rsp queue drained", 32'(rsp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pad_cfg_sequencer.md
# pad_cfg_sequencer

Parametrised configuration sequencer for the user-project GPIO pad ring. It holds one configuration word per `mprj_io` pad in a local register file written by the management core. On command, it serially shifts every word into the per-pad control blocks over NUM_CHAINS independent chains, then pulses a common load strobe. It sits between the management SoC and the pad-control chains that drive `mprj_io_oeb`, `mprj_io_dm`, `mprj_io_inp_dis` and related pad controls.

## Interface
Parameters:
- NUM_PADS, 38: number of user pads; must be divisible by NUM_CHAINS.
- NUM_CHAINS, 2: number of parallel serial chains.
- CFG_BITS, 13: configuration bits per pad.
- CFG_RESET, 13'h0403: reset value of every register-file word.

Ports:
- clock, input, 1: sole clock.
- resetb, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: register-file write strobe.
- wr_addr, input, $clog2(NUM_PADS): pad index to write.
- wr_data, input, CFG_BITS: configuration word to write.
- wr_err, output, 1: one-cycle pulse when a write is rejected.
- rd_addr, input, $clog2(NUM_PADS): pad index to read.
- rd_data, output, CFG_BITS: registered read data.
- start, input, 1: request a full-ring shift and load.
- busy, output, 1: sequence in progress.
- done, output, 1: one-cycle pulse when the sequence completes.
- serial_clock, output, 1: shift clock shared by all chains.
- serial_load, output, 1: latch strobe shared by all chains.
- serial_data_out, output, NUM_CHAINS: one data bit per chain.

## Operation
- Chain mapping:
  - P = NUM_PADS/NUM_CHAINS.
  - Chain c carries pads c*P .. c*P+P-1; pad c*P is nearest the sequencer.
- Shift order per chain: farthest pad first (index c*P+P-1), MSB first, ending with pad c*P bit 0.
- State machine:
  - IDLE: `start`=1 → SHIFT; bit counter loaded to P*CFG_BITS-1.
  - SHIFT, two phases per bit:
    - Phase 0: present the bit on `serial_data_out` with `serial_clock`=0.
    - Phase 1: drive `serial_clock`=1.
    - After phase 1 of bit 0 → LOAD.
  - LOAD: `serial_load`=1 for 2 cycles, `serial_clock`=0 → FIN.
  - FIN: `done`=1 for 1 cycle, `busy` drops → IDLE.
- `start` is ignored outside IDLE. A `start` held high in IDLE re-triggers a new sequence immediately after FIN.
- Writes:
  - Accepted only in IDLE.
  - A write during SHIFT, LOAD or FIN is dropped and `wr_err` pulses the next cycle.
  - A write with `wr_addr` >= NUM_PADS is dropped and `wr_err` pulses.
- Write and `start` in the same IDLE cycle: the write lands first, and the shift uses the new value.
- Read: `rd_data` returns the word at `rd_addr` one cycle later, in any state. An out-of-range `rd_addr` returns 0.
- Reset (async, any time, including mid-SHIFT):
  - State → IDLE, counters cleared.
  - All outputs 0.
  - Register file → CFG_RESET.
  - Downstream pads keep their previously latched configuration, because `serial_load` never fired.

## Timing
- `start` is sampled at edge 0. `busy`=1 and the first data bit appear after edge 0.
- Rising `serial_clock` edges occur at cycles 2k+1, for k = 0 .. P*CFG_BITS-1.
- `busy` lasts 2*P*CFG_BITS + 3 cycles (SHIFT + LOAD + FIN). With default parameters this is 497 cycles.
- `done` is asserted in the last `busy` cycle.
- `serial_data_out` is stable for the full 2-cycle bit period. It changes only in phase 0, when `serial_clock`=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: `busy`, `done`, `wr_err`, `serial_clock`, `serial_load`, `serial_data_out` and `rd_data` are all 0.

## Structure
- Package `pad_cfg_pkg`:
  - State enum {IDLE, SHIFT, LOAD, FIN}.
  - Default CFG_BITS and CFG_RESET.
  - Field offsets for the configuration word:
    - bit 0 mgmt_en, bit 1 oeb, bit 2 holdover, bit 3 inp_dis, bit 4 ib_mode_sel, bit 5 analog_en, bit 6 analog_sel, bit 7 analog_pol, bit 8 slow_sel, bit 9 vtrip_sel, bits 12:10 dm.
- Sub-module `pad_cfg_chain_shift`:
  - One instance per chain.
  - Selects the current pad word and bit from the shared counter and registers `serial_data_out[c]`.
- The top level owns the FSM, counter, register file and strobes.

## Test plan
- Reset, then `start` with no writes → 497-cycle `busy`; every chain shifts 19 copies of 13'h0403 MSB-first, then `serial_load` high for 2 cycles, then `done`.
- Write pad 18 = 13'h1FFF and pad 0 = 13'h0001, then `start` → chain 0 first bits are 1×13 (pad 18); its last 13 bits are 0…01 (pad 0).
- Write to pad 5 during SHIFT → `wr_err` pulses; `rd_data`(5) is unchanged; the shifted stream is unchanged.
- `start` pulsed mid-SHIFT → ignored; `busy` length is still 497 cycles.
- Assert `resetb` low at cycle 100 of SHIFT → all outputs 0 immediately; `serial_load` never asserted; `rd_data` returns 13'h0403 for any pad after release.
- Write to `wr_addr`=40 → `wr_err` pulses; `rd_addr`=40 returns 0.
